// File: rtl/inv_butterfly_pkg.sv
// Shared FFT datapath definitions: butterfly FSM states, a complex sample type
// at the default component width, and fixed-point constants.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CPLX_W   = 32;
    localparam int FRAC_DEF = 16;

    // Complex sample at the default width; blocks built for other widths declare their own.
    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    localparam logic [CPLX_W-1:0] FX_ONE = 32'd1 << FRAC_DEF;

    // Fixed-point one for an arbitrary number of fractional bits.
    function automatic logic [63:0] fx_one(input int frac);
        fx_one = 64'd1 << frac;
    endfunction

endpackage

// File: rtl/inv_butterfly_if.sv
// Handshake and data bundle between the inverse butterfly and its neighbours.
// The slave side is the butterfly; the master side feeds c/d/w and drains a/b.
interface inv_butterfly_if #(
    parameter int N = 32
);
    logic         recv_val;
    logic         recv_rdy;
    logic [N-1:0] cr, cc, dr, dc, wr, wc;
    logic         send_val;
    logic         send_rdy;
    logic [N-1:0] ar, ac, br, bc;

    modport master (
        output recv_val, cr, cc, dr, dc, wr, wc, send_rdy,
        input  recv_rdy, send_val, ar, ac, br, bc
    );

    modport slave (
        input  recv_val, cr, cc, dr, dc, wr, wc, send_rdy,
        output recv_rdy, send_val, ar, ac, br, bc
    );
endinterface

// File: rtl/inv_butterfly_cmul.sv
// Bit-serial signed multiply of t by conj(w): one bit of t per cycle, LSB first,
// with the sign bit subtracted. The final iteration's sum is exposed combinationally.
module inv_bfly_cmul
    import fft_pkg::*;
#(
    parameter int N = 32,
    parameter int D = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic [N-1:0] i_wr,
    input  logic [N-1:0] i_wc,
    input  logic [N:0]   i_tr,
    input  logic [N:0]   i_tc,
    output logic         o_done,
    output logic [N-1:0] o_br,
    output logic [N-1:0] o_bc
);
    localparam int AW = 2*N + 2;
    localparam int CW = $clog2(N + 2);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_wr_sh, r_wc_sh;
    logic [N:0]    r_tr_sh, r_tc_sh;
    logic [AW-1:0] r_acc_rr, r_acc_cc, r_acc_rc, r_acc_cr;

    logic          w_last;
    logic [AW-1:0] w_rr_nx, w_cc_nx, w_rc_nx, w_cr_nx;
    logic [AW-1:0] w_re, w_im;

    // Partial product for one bit of t; the top bit carries negative weight.
    function automatic logic [AW-1:0] pp_term(input logic bit_v, input logic neg,
                                              input logic [AW-1:0] val);
        if (!bit_v) begin
            pp_term = '0;
        end else if (neg) begin
            pp_term = -val;
        end else begin
            pp_term = val;
        end
    endfunction

    assign w_last  = (r_cnt == CW'(N));
    assign w_rr_nx = r_acc_rr + pp_term(r_tr_sh[0], w_last, r_wr_sh);
    assign w_cc_nx = r_acc_cc + pp_term(r_tc_sh[0], w_last, r_wc_sh);
    assign w_rc_nx = r_acc_rc + pp_term(r_tc_sh[0], w_last, r_wr_sh);
    assign w_cr_nx = r_acc_cr + pp_term(r_tr_sh[0], w_last, r_wc_sh);
    assign w_re    = w_rr_nx + w_cc_nx;
    assign w_im    = w_rc_nx - w_cr_nx;

    // Floor shift by d+1 then keep the low n bits (wraps, no saturation).
    assign o_br   = w_re[D+1 +: N];
    assign o_bc   = w_im[D+1 +: N];
    assign o_done = r_busy && w_last;

    // Operand load on start, then one shift-and-accumulate step per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_wr_sh  <= '0;
            r_wc_sh  <= '0;
            r_tr_sh  <= '0;
            r_tc_sh  <= '0;
            r_acc_rr <= '0;
            r_acc_cc <= '0;
            r_acc_rc <= '0;
            r_acc_cr <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_wr_sh  <= {{(AW-N){i_wr[N-1]}}, i_wr};
            r_wc_sh  <= {{(AW-N){i_wc[N-1]}}, i_wc};
            r_tr_sh  <= i_tr;
            r_tc_sh  <= i_tc;
            r_acc_rr <= '0;
            r_acc_cc <= '0;
            r_acc_rc <= '0;
            r_acc_cr <= '0;
        end else if (r_busy) begin
            r_busy   <= !w_last;
            r_cnt    <= r_cnt + CW'(1);
            r_wr_sh  <= r_wr_sh << 1;
            r_wc_sh  <= r_wc_sh << 1;
            r_tr_sh  <= r_tr_sh >> 1;
            r_tc_sh  <= r_tc_sh >> 1;
            r_acc_rr <= w_rr_nx;
            r_acc_cc <= w_cc_nx;
            r_acc_rc <= w_rc_nx;
            r_acc_cr <= w_cr_nx;
        end else begin
            r_busy <= 1'b0;
        end
    end
endmodule

// File: rtl/inv_butterfly.sv
// Inverse radix-2 butterfly: a = (c+d)/2, b = conj(w)*(c-d)/2, one transaction
// in flight, val/rdy on both sides.
module inv_butterfly
    import fft_pkg::*;
#(
    parameter int N    = 32,
    parameter int D    = 16,
    parameter int MULT = 1
) (
    input  logic           clk,
    input  logic           reset,
    inv_butterfly_if.slave bus
);
    localparam bit HAS_MUL = (MULT != 0);

    state_e       r_state, w_state_nx;
    logic         w_accept;
    logic [N:0]   w_sr, w_sc, w_tr, w_tc;
    logic [N-1:0] r_ar, r_ac, r_br, r_bc;
    logic         w_cmul_done;
    logic [N-1:0] w_mbr, w_mbc;

    // n+1-bit sum/difference so full-scale inputs cannot overflow.
    assign w_sr = {bus.cr[N-1], bus.cr} + {bus.dr[N-1], bus.dr};
    assign w_sc = {bus.cc[N-1], bus.cc} + {bus.dc[N-1], bus.dc};
    assign w_tr = {bus.cr[N-1], bus.cr} - {bus.dr[N-1], bus.dr};
    assign w_tc = {bus.cc[N-1], bus.cc} - {bus.dc[N-1], bus.dc};

    generate
        if (HAS_MUL) begin : g_cmul
            inv_bfly_cmul #(.N(N), .D(D)) u_cmul (
                .clk     (clk),
                .reset   (reset),
                .i_start (w_accept),
                .i_wr    (bus.wr),
                .i_wc    (bus.wc),
                .i_tr    (w_tr),
                .i_tc    (w_tc),
                .o_done  (w_cmul_done),
                .o_br    (w_mbr),
                .o_bc    (w_mbc)
            );
        end else begin : g_nomul
            assign w_cmul_done = 1'b0;
            assign w_mbr       = '0;
            assign w_mbc       = '0;
        end
    endgenerate

    // Next-state decode; input is only taken while idle.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.recv_val) begin
                    w_accept   = 1'b1;
                    w_state_nx = HAS_MUL ? CALC : DONE;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            CALC: begin
                if (w_cmul_done) begin
                    w_state_nx = DONE;
                end else begin
                    w_state_nx = CALC;
                end
            end
            DONE: begin
                if (bus.send_rdy) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = DONE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State and result registers; a is captured at accept, b when it is known.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ar    <= '0;
            r_ac    <= '0;
            r_br    <= '0;
            r_bc    <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_ar <= w_sr[N:1];
                r_ac <= w_sc[N:1];
            end
            if (w_accept && !HAS_MUL) begin
                r_br <= w_tr[N:1];
                r_bc <= w_tc[N:1];
            end else if ((r_state == CALC) && w_cmul_done) begin
                r_br <= w_mbr;
                r_bc <= w_mbc;
            end
        end
    end

    assign bus.recv_rdy = (r_state == IDLE);
    assign bus.send_val = (r_state == DONE);
    assign bus.ar       = r_ar;
    assign bus.ac       = r_ac;
    assign bus.br       = r_br;
    assign bus.bc       = r_bc;
endmodule
